mcu_target_dispatch: RTL
========================

# mcu_target_dispatch

Routes the MCU byte stream to the core's MCU-facing targets: system control, HID, OSD, SD card and so on. Each frame begins with a target-select byte. The block demultiplexes the remaining bytes of the frame onto per-target strobes with a regenerated frame-start flag, and multiplexes the selected target's `data_out` back to the MCU. It also aggregates per-target interrupt requests into the single active-low MCU interrupt line. It sits between the MCU SPI byte receiver and the target blocks.

## Interface
Parameters:
- `NUM_TARGETS`, default 4, range 1..8: number of attached targets; target index width is `TW = max(1, clog2(NUM_TARGETS))`.

Ports:
- `clk`  in  1  system clock; single clock domain; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `spi_strobe`  in  1  one-cycle pulse; `spi_din` holds a valid byte.
- `spi_start`  in  1  qualified by `spi_strobe`; marks the first byte of a frame.
- `spi_din`  in  8  byte from the MCU.
- `spi_dout`  out  8  byte returned to the MCU; registered.
- `tgt_strobe`  out  NUM_TARGETS  one-hot, one-cycle byte strobe to the selected target.
- `tgt_start`  out  1  valid with `tgt_strobe`; first payload byte of the frame.
- `tgt_din`  out  8  payload byte, shared by all targets.
- `tgt_dout`  in  8*NUM_TARGETS  packed per-target `data_out`; target i is at `[8i+7:8i]`.
- `irq_req`  in  NUM_TARGETS  level interrupt requests from the targets.
- `int_out_n`  out  1  active-low MCU interrupt; registered.
- `err_cnt`  out  8  count of frames with an invalid target byte; saturating.

## Operation
- The FSM has three states: IDLE, HDR, PAYLOAD. DROP is an additional sub-state used for invalid frames.
- A start byte (`spi_strobe && spi_start`) is accepted in any state, which aborts any frame in progress:
  - Latch `sel <= spi_din[TW-1:0]`.
  - If `spi_din < NUM_TARGETS`, go to HDR. Otherwise go to DROP and increment `err_cnt`, saturating at 255.
  - `spi_dout <= {8-NUM_TARGETS zero bits, irq_req}` (the interrupt snapshot).
- First byte in HDR (strobe, no start): pulse `tgt_strobe[sel]`, set `tgt_start=1`, `tgt_din <= spi_din`, go to PAYLOAD. `spi_dout <= tgt_dout[sel]`.
- Bytes in PAYLOAD: same forwarding with `tgt_start=0`. `spi_dout <= tgt_dout[sel]` is sampled on the strobe cycle. The MCU therefore sees each target response one byte late; this is intended.
- Bytes in DROP: nothing is forwarded; `spi_dout <= 8'hFF`.
- Bytes in IDLE without start (after reset, before any frame): ignored; `spi_dout <= 8'h00`.
- `spi_start` without `spi_strobe` is ignored.
- The frame end is implicit; a frame lasts until the next start byte. The start byte itself is never forwarded.
- Interrupt line: `int_out_n <= ~|irq_req` every cycle. Clearing requests is the targets' responsibility (per-target iack protocol); this block keeps no pending state.

## Timing
- Reset values:
  - state IDLE, `sel` 0
  - `spi_dout` 8'h00
  - `tgt_strobe` all 0, `tgt_start` 0, `tgt_din` 8'h00
  - `int_out_n` 1, `err_cnt` 0
- Forward latency: `tgt_strobe`/`tgt_start`/`tgt_din` appear exactly 1 cycle after the `spi_strobe` cycle, high for exactly 1 cycle.
- `spi_dout` updates 1 cycle after `spi_strobe` and holds until the next strobe.
- Back-to-back strobes on consecutive cycles are supported at full rate, with no bubbles and no dropped bytes.
- A start byte on the cycle immediately after a payload byte still produces that payload byte's `tgt_strobe`. The new frame's state takes effect on the same cycle.
- `tgt_start` is never high without a `tgt_strobe` bit. At most one `tgt_strobe` bit is high per cycle.
- `int_out_n` follows `irq_req` with 1 cycle latency.
- Reset asserted mid-frame returns to IDLE on the next edge. Any strobe coincident with reset is discarded.
- `err_cnt` at 255 stays 255 on further invalid frames.

## Test plan
- Reset, then send start 0x00 followed by 0x03, 0xAA, 0x55 -> `tgt_strobe` = 0001 on three cycles, each 1 cycle after the strobe. `tgt_start`=1 only with `tgt_din`=0x03; then 0xAA and 0x55 with `tgt_start`=0.
- Drive `tgt_dout[15:8]`=0x5C, start 0x01, `irq_req`=0010, then send 3 payload bytes -> `spi_dout` = 0x02 after the start byte, then 0x5C on each payload byte. Only `tgt_strobe[1]` pulses.
- `NUM_TARGETS`=4, start 0x07, then 2 bytes -> no `tgt_strobe`, `spi_dout`=0xFF on both, `err_cnt`=1. Repeat 300 invalid frames -> `err_cnt` stays 255.
- Send start 0x02 and 1 payload byte, then start 0x00 and byte 0x10 on back-to-back cycles -> target 2 receives one byte; target 0 receives 0x10 with `tgt_start`=1; no lost or duplicated strobes.
- Assert `reset` during PAYLOAD, then send non-start bytes -> no `tgt_strobe`, `spi_dout`=0x00, `int_out_n`=1.
- Raise `irq_req[3]` on cycle N -> `int_out_n`=0 on N+1; drop it -> `int_out_n`=1 one cycle later.

Source files
------------

// File: rtl/mcu_target_dispatch.sv
// mcu_target_dispatch: demuxes MCU SPI frames onto per-target strobes, muxes target data back, aggregates irqs.
module mcu_target_dispatch #(
    parameter int NUM_TARGETS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     spi_strobe,
    input  logic                     spi_start,
    input  logic [7:0]               spi_din,
    output logic [7:0]               spi_dout,
    output logic [NUM_TARGETS-1:0]   tgt_strobe,
    output logic                     tgt_start,
    output logic [7:0]               tgt_din,
    input  logic [8*NUM_TARGETS-1:0] tgt_dout,
    input  logic [NUM_TARGETS-1:0]   irq_req,
    output logic                     int_out_n,
    output logic [7:0]               err_cnt
);
    localparam int TW = NUM_TARGETS > 1 ? $clog2(NUM_TARGETS) : 1;
    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;
    state_t state;
    logic [TW-1:0] sel;
    logic [7:0] sel_dout;
    logic valid;
    always_comb begin
        sel_dout = tgt_dout[{sel, 3'b000} +: 8];
        valid    = 32'(spi_din) < NUM_TARGETS;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= '0;
            spi_dout   <= 8'h00;
            tgt_strobe <= '0;
            tgt_start  <= 1'b0;
            tgt_din    <= 8'h00;
            int_out_n  <= 1'b1;
            err_cnt    <= 8'h00;
        end else begin
            tgt_strobe <= '0;
            tgt_start  <= 1'b0;
            int_out_n  <= ~|irq_req;
            if (spi_strobe && spi_start) begin
                sel      <= spi_din[TW-1:0];
                state    <= valid ? HDR : DROP;
                err_cnt  <= (valid || err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
                spi_dout <= 8'(irq_req);
            end else if (spi_strobe) begin
                if (state == HDR || state == PAYLOAD) begin
                    tgt_strobe <= NUM_TARGETS'(1) << sel;
                    tgt_start  <= state == HDR;
                    tgt_din    <= spi_din;
                    state      <= PAYLOAD;
                    spi_dout   <= sel_dout;
                end else begin
                    spi_dout <= state == DROP ? 8'hFF : 8'h00;
                end
            end
        end
    end
endmodule
